// File: rtl/serial_tx_scheduler_pkg.sv
// Shared types and constants for the two-requester 8N1 serial transmit scheduler.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS           = 10;
  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Round-robin pick: 1 selects requester 1. On contention the requester
  // that did not own the previous frame wins.
  function automatic logic rr_pick(input logic last, input logic r0, input logic r1);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester handshake plus serial line status bundled for the scheduler.
interface serial_tx_scheduler_if;
  import serial_pkg::*;

  logic                 req0;
  logic [DATA_BITS-1:0] data0;
  logic                 ack0;
  logic                 req1;
  logic [DATA_BITS-1:0] data1;
  logic                 ack1;
  logic                 dout;
  logic                 busy;
  logic                 grant_id;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, dout, busy, grant_id
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, dout, busy, grant_id
  );

endinterface

// File: rtl/serial_tx_scheduler_core.sv
// 8N1 frame serialiser: baud counter, shift register and frame FSM.
module serial_tx_core
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 dout
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t            state;
  logic [BAUD_W-1:0]    baud;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      dout    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_cnt <= '0;
          if (load) begin
            shreg <= data;
            dout  <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            dout  <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == LAST_BIT) begin
              dout  <= 1'b1;
              state <= STOP;
            end else begin
              // dout already shows shreg[0]; present the next bit as we shift
              shreg   <= shreg >> 1;
              dout    <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dout  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Two-requester round-robin front end feeding a single 8N1 serial transmitter.
module serial_tx_scheduler
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_tx_scheduler_if.slave  bus
);

  logic                 core_busy;
  logic                 core_dout;
  logic                 gnt_vld;
  logic                 gnt_sel;
  logic [DATA_BITS-1:0] load_data;
  logic                 ack0_r;
  logic                 ack1_r;
  logic                 gid_r;

  // Requests are only considered while the transmitter sits in IDLE.
  always_comb begin
    gnt_vld   = !core_busy && (bus.req0 || bus.req1);
    gnt_sel   = rr_pick(gid_r, bus.req0, bus.req1);
    load_data = gnt_sel ? bus.data1 : bus.data0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      gid_r  <= 1'b1;
    end else begin
      ack0_r <= gnt_vld && !gnt_sel;
      ack1_r <= gnt_vld &&  gnt_sel;
      if (gnt_vld) gid_r <= gnt_sel;
    end
  end

  serial_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gnt_vld),
    .data  (load_data),
    .busy  (core_busy),
    .dout  (core_dout)
  );

  assign bus.ack0     = ack0_r;
  assign bus.ack1     = ack1_r;
  assign bus.grant_id = gid_r;
  assign bus.dout     = core_dout;
  assign bus.busy     = core_busy;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: fast-rate instance with frame scoreboard, plus a default-rate instance.
module tb_serial_tx_scheduler;
  import serial_pkg::*;

  localparam int CA = 4;
  localparam int CB = DEFAULT_CLKS_PER_BIT;

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    int         n;
    logic       g_a;
    logic [7:0] x_a;
    logic       g_b;
    logic [7:0] x_b;
  } vec_t;

  typedef struct {
    logic       gid;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  serial_tx_scheduler_if ia ();
  serial_tx_scheduler_if ib ();

  serial_tx_scheduler #(.CLKS_PER_BIT(CA)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ia.slave));
  serial_tx_scheduler #(.CLKS_PER_BIT(CB)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ib.slave));

  int   vec = 0;
  int   miscmp = 0;
  exp_t exp_q[$];
  int   fstart[$];
  int   fend[$];
  int   cyc = 0, mcnt = 0, frames_done = 0;
  int   ack0_n = 0, ack1_n = 0, ack1_cyc = 0;
  bit   mact = 0, mglitch = 0, mchk_idle = 0, prev_ack0 = 0, prev_ack1 = 0;
  logic [9:0] mbits;
  logic mgid;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame monitor and ack observer for the fast instance
  always @(negedge clk) begin
    exp_t e;
    int   bi;
    cyc++;
    if (!rst_a) begin
      mact = 0; mchk_idle = 0; prev_ack0 = 0; prev_ack1 = 0;
    end else begin
      if (ia.ack0 || ia.ack1) check("ack_onehot", 32'(ia.ack0 & ia.ack1), 0);
      if (ia.ack0) begin check("ack0_width", 32'(prev_ack0), 0); ack0_n++; end
      if (ia.ack1) begin check("ack1_width", 32'(prev_ack1), 0); ack1_n++; ack1_cyc = cyc; end
      prev_ack0 = ia.ack0;
      prev_ack1 = ia.ack1;
      if (mchk_idle) begin
        mchk_idle = 0;
        check("idle_busy", 32'(ia.busy), 0);
        check("idle_dout", 32'(ia.dout), 1);
      end else if (!mact && ia.dout == 1'b0) begin
        mact = 1; mcnt = 0; mglitch = 0; mgid = ia.grant_id;
        fstart.push_back(cyc);
        check("start_ack", 32'(ia.grant_id ? ia.ack1 : ia.ack0), 1);
      end
      if (mact) begin
        bi = mcnt / CA;
        if (mcnt % CA == 0) mbits[bi] = ia.dout;
        else if (ia.dout !== mbits[bi]) mglitch = 1;
        if (ia.busy !== 1'b1) mglitch = 1;
        mcnt++;
        if (mcnt == FRAME_BITS * CA) begin
          mact = 0; mchk_idle = 1; frames_done++;
          fend.push_back(cyc);
          check("start_bit", 32'(mbits[0]), 0);
          check("stop_bit", 32'(mbits[9]), 1);
          check("bit_timing_busy", 32'(mglitch), 0);
          check("frame_queue_empty", 32'(exp_q.size() == 0), 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_data", 32'(mbits[8:1]), 32'(e.data));
            check("frame_gid", 32'(mgid), 32'(e.gid));
          end
        end
      end
    end
  end

  task automatic wait_frames(input int tgt, input int budget, input string nm);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk); #1;
      if (frames_done >= tgt) ok = 1;
    end
    check(nm, 32'(ok), 1);
  endtask

  task automatic wait_ack(input bit which, input int budget, input string nm);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk); #1;
      if (which == 0 && ia.ack0) begin ok = 1; ia.req0 = 0; end
      if (which == 1 && ia.ack1) begin ok = 1; ia.req1 = 0; end
    end
    check(nm, 32'(ok), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int a0, a1, tgt, n0, n1;
    bit done = 0;
    a0 = ack0_n; a1 = ack1_n; tgt = frames_done + v.n;
    n0 = (v.g_a == 0) ? 1 : 0;
    n1 = 1 - n0;
    exp_q.push_back('{v.g_a, v.x_a});
    if (v.n == 2) begin
      exp_q.push_back('{v.g_b, v.x_b});
      if (v.g_b == 0) n0++; else n1++;
    end
    ia.data0 = v.d0; ia.data1 = v.d1; ia.req0 = v.r0; ia.req1 = v.r1;
    for (int c = 0; c < 30 * CA + 20 && !done; c++) begin
      @(posedge clk); #1;
      if (ia.ack0) ia.req0 = 0;
      if (ia.ack1) ia.req1 = 0;
      if (frames_done >= tgt && !ia.req0 && !ia.req1) done = 1;
    end
    check("vec_done", 32'(done), 1);
    ia.req0 = 0; ia.req1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("vec_ack0_count", 32'(ack0_n - a0), 32'(n0));
    check("vec_ack1_count", 32'(ack1_n - a1), 32'(n1));
  endtask

  vec_t tbl[7];

  initial begin
    int   a0, a1, f0, nack, lows, start_len, busy_cnt, b_acks;
    bit   inrun;
    logic [10:0] bbits;

    rst_a = 0; rst_b = 0;
    ia.req0 = 0; ia.req1 = 0; ia.data0 = 0; ia.data1 = 0;
    ib.req0 = 0; ib.req1 = 0; ib.data0 = 0; ib.data1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 32'(ia.dout), 1);
    check("rst_busy", 32'(ia.busy), 0);
    check("rst_ack0", 32'(ia.ack0), 0);
    check("rst_ack1", 32'(ia.ack1), 0);
    check("rst_grant_id", 32'(ia.grant_id), 1);
    check("rst_b_dout", 32'(ib.dout), 1);
    rst_a = 1; rst_b = 1;
    @(posedge clk); #1;

    // {req0, req1, data0, data1, frames, gid1, byte1, gid2, byte2}
    tbl[0] = '{1, 1, 8'h11, 8'h22, 2, 0, 8'h11, 1, 8'h22};
    tbl[1] = '{1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5, 0, 8'h00};
    tbl[2] = '{0, 1, 8'h00, 8'h3C, 1, 1, 8'h3C, 0, 8'h00};
    tbl[3] = '{1, 0, 8'h5A, 8'h00, 1, 0, 8'h5A, 0, 8'h00};
    tbl[4] = '{1, 1, 8'h7E, 8'h81, 2, 1, 8'h81, 0, 8'h7E};
    tbl[5] = '{1, 1, 8'h00, 8'hFF, 2, 1, 8'hFF, 0, 8'h00};
    tbl[6] = '{0, 1, 8'h00, 8'h80, 1, 1, 8'h80, 0, 8'h00};
    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i]);
      if (i == 0 && fend.size() >= 1 && fstart.size() >= 2)
        check("contend_gap", 32'(fstart[1] - fend[0]), 2);
    end

    // Fairness: both requests held for four frames
    a0 = ack0_n; a1 = ack1_n; f0 = frames_done; nack = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back('{logic'(k % 2), (k % 2) ? 8'h3C : 8'hC3});
    ia.data0 = 8'hC3; ia.data1 = 8'h3C; ia.req0 = 1; ia.req1 = 1;
    for (int c = 0; c < 50 * CA + 40 && nack < 4; c++) begin
      @(posedge clk); #1;
      if (ia.ack0 || ia.ack1) nack++;
    end
    ia.req0 = 0; ia.req1 = 0;
    wait_frames(f0 + 4, 15 * CA, "fair_frames");
    repeat (2) @(posedge clk);
    #1;
    check("fair_ack0", 32'(ack0_n - a0), 2);
    check("fair_ack1", 32'(ack1_n - a1), 2);

    // Request raised while requester 0's frame is in its data phase
    f0 = frames_done;
    exp_q.push_back('{1'b0, 8'h96});
    exp_q.push_back('{1'b1, 8'h69});
    ia.data0 = 8'h96; ia.req0 = 1;
    wait_ack(0, 10, "mid_ack0");
    for (int c = 0; c < 40 && !(mact && mcnt >= 5 * CA); c++) begin @(posedge clk); #1; end
    ia.data1 = 8'h69; ia.req1 = 1;
    wait_ack(1, 15 * CA, "mid_ack1");
    @(negedge clk); #1;
    if (fend.size() > 0) check("mid_ack1_timing", 32'(ack1_cyc - fend[fend.size()-1]), 2);
    wait_frames(f0 + 2, 15 * CA, "mid_frames");
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset during data bit 3
    f0 = frames_done;
    ia.data0 = 8'hF0; ia.req0 = 1;
    wait_ack(0, 10, "rst_mid_ack0");
    for (int c = 0; c < 40 && !(mact && mcnt >= 4 * CA + 1); c++) begin @(posedge clk); #1; end
    #2;
    rst_a = 0;
    #1;
    check("abort_dout", 32'(ia.dout), 1);
    check("abort_busy", 32'(ia.busy), 0);
    check("abort_ack0", 32'(ia.ack0), 0);
    check("abort_grant_id", 32'(ia.grant_id), 1);
    repeat (2) @(posedge clk);
    #2;
    rst_a = 1;
    a0 = ack0_n; a1 = ack1_n; lows = 0;
    for (int c = 0; c < 30 * CA; c++) begin
      @(posedge clk); #1;
      if (ia.dout !== 1'b1) lows++;
    end
    check("post_rst_line_low", 32'(lows), 0);
    check("post_rst_acks", 32'((ack0_n - a0) + (ack1_n - a1)), 0);
    check("post_rst_frames", 32'(frames_done - f0), 0);

    // Default baud rate on the second instance
    ib.data1 = 8'h63; ib.req1 = 1;
    inrun = 0;
    for (int c = 0; c < 10 && !inrun; c++) begin
      @(posedge clk); #1;
      if (ib.ack1) begin inrun = 1; ib.req1 = 0; end
    end
    check("b_ack1_seen", 32'(inrun), 1);
    start_len = 0; busy_cnt = 0; b_acks = 0; bbits = '1;
    for (int j = 0; j < 10 * CB + 4; j++) begin
      if (inrun && ib.dout == 1'b0) start_len++; else inrun = 0;
      if (ib.busy) busy_cnt++;
      if (ib.ack1) b_acks++;
      if (j % CB == CB / 2) bbits[j / CB] = ib.dout;
      @(posedge clk); #1;
    end
    check("b_start_len", 32'(start_len), 32'(CB));
    check("b_busy_len", 32'(busy_cnt), 32'(FRAME_BITS * CB));
    check("b_data", 32'(bbits[8:1]), 32'h63);
    check("b_start_bit", 32'(bbits[0]), 0);
    check("b_stop_bit", 32'(bbits[9]), 1);
    check("b_ack_pulses", 32'(b_acks), 1);
    check("b_grant_id", 32'(ib.grant_id), 1);
    check("b_idle_dout", 32'(ib.dout), 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/serial_tx_scheduler.md
# serial_tx_scheduler

Shares one asynchronous serial output line between two byte requesters. Round-robin arbitration selects a requester, latches its byte and serialises it as an 8N1 frame on `dout` at a fixed baud rate set by a clock divider. It sits in front of the line receiver side of `serial_transceiver`. `dout` uses the same bit timing as that block: idle high, 5208 clocks per bit at the default setting.

## Interface
- `CLKS_PER_BIT`, 5208, clocks per serial bit; legal range ≥ 2
- `clk` input 1 system clock, all state on rising edge
- `rst_n` input 1 asynchronous active-low reset
- `req0` input 1 requester 0 has a byte to send; held until `ack0`
- `data0` input 8 requester 0 byte; stable while `req0` is high
- `ack0` output 1 one-cycle pulse: `data0` latched, `req0` may drop
- `req1` input 1 requester 1 request; same rules as `req0`
- `data1` input 8 requester 1 byte
- `ack1` output 1 one-cycle pulse for requester 1
- `dout` output 1 serial line, idles high
- `busy` output 1 high while a frame is in progress (START..STOP)
- `grant_id` output 1 requester of the current or most recent frame

## Operation
- States are IDLE, START, DATA and STOP.
- Reset values: state IDLE, `dout`=1, `busy`=0, `ack0`=`ack1`=0, `grant_id`=1, bit counter 0, baud counter 0. `grant_id` resets to 1 so that requester 0 wins the first contention.
- **IDLE**
  - If no `req` is high, stay in IDLE with `dout`=1.
  - If exactly one `req` is high, grant it.
  - If both are high, grant the requester ≠ `grant_id` (round-robin).
  - On the granting edge:
    - latch the byte into the shift register
    - set `grant_id`
    - pulse the matching `ack` for 1 cycle
    - set `dout`←0 and `busy`←1
    - go to START
- **START**: hold `dout`=0 for `CLKS_PER_BIT` clocks, then go to DATA.
- **DATA**
  - Send 8 bits LSB first, each for `CLKS_PER_BIT` clocks.
  - `dout` is the shift-register LSB; shift right at each bit boundary.
  - After bit 7 go to STOP.
- **STOP**
  - Hold `dout`=1 for `CLKS_PER_BIT` clocks.
  - Then go to IDLE with `busy`←0.
- Requests are sampled only in IDLE. A `req` raised or dropped mid-frame has no effect on the current frame. A `req` dropped before its `ack` is simply not served.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary.
- `rst_n` low at any time:
  - all registers immediately return to their reset values
  - `dout`=1 asynchronously; the frame is aborted
  - no `ack` is issued for the aborted frame

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request to line: if `req` is sampled high in IDLE at edge k, then `ack` is high and `dout`=0 during cycle k..k+1.
- Frame length is exactly `10*CLKS_PER_BIT` clocks from the falling edge of `dout` to the end of the stop bit.
- Between back-to-back frames there is 1 idle clock with `dout`=1, then the next start bit. Minimum frame spacing is `10*CLKS_PER_BIT+1` clocks.
- `busy` rises with the start bit and falls on the edge where the state returns to IDLE.
- An `ack` pulse lasts exactly 1 cycle; at most one `ack` is high per cycle.

## Structure
- Package `serial_pkg`:
  - state enum (IDLE, START, DATA, STOP)
  - `FRAME_BITS`=10 and `DATA_BITS`=8
  - the default `CLKS_PER_BIT`
- Sub-module `serial_tx_core` holds the baud counter, shift register and frame FSM. Its handshake is `load`/`data`/`busy`/`dout`.
- The top level holds the round-robin arbiter, the `ack` generation and `grant_id`.

## Test plan
- **Single frame.** `CLKS_PER_BIT`=4, `req0` with `data0`=8'hA5.
  - `ack0` pulses once.
  - `dout` per 4-clock bit is 0,1,0,1,0,0,1,0,1,1.
  - `busy` stays high for 40 clocks.
- **Contention after reset.** `req0` and `req1` rise on the same edge, data 8'h11 and 8'h22, both held until acked.
  - Frame 1 is 8'h11 with `grant_id`=0.
  - Frame 2 is 8'h22 with `grant_id`=1, starting exactly 1 idle clock after frame 1's stop bit.
- **Fairness under load.** Both requesters held continuously for 4 frames → `grant_id` sequence 0,1,0,1 and exactly 2 `ack` pulses each.
- **Request during a frame.** `req1` raised in the middle of requester 0's DATA phase.
  - Current frame is unchanged.
  - `ack1` arrives on the first IDLE cycle after the stop bit.
- **Reset mid-frame.** `rst_n` low during bit 3 of the DATA phase.
  - `dout`=1 and `busy`=0 immediately.
  - After release with no request, the line stays idle high and no `ack` appears.
- **Default rate.** `CLKS_PER_BIT`=5208, `req1` with 8'h63.
  - Start bit lasts 5208 clocks.
  - Total frame is 52080 clocks.
  - Bits decode to 8'h63.
